// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and decode function for display blocks.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_pat_t;

  // Active-high patterns, bit order {a,b,c,d,e,f,g}
  localparam seg_pat_t SEG_BLANK = 7'b000_0000;
  localparam seg_pat_t SEG_PAT_0 = 7'b111_1110;
  localparam seg_pat_t SEG_PAT_1 = 7'b011_0000;
  localparam seg_pat_t SEG_PAT_2 = 7'b110_1101;
  localparam seg_pat_t SEG_PAT_3 = 7'b111_1001;
  localparam seg_pat_t SEG_PAT_4 = 7'b011_0011;
  localparam seg_pat_t SEG_PAT_5 = 7'b101_1011;
  localparam seg_pat_t SEG_PAT_6 = 7'b101_1111;
  localparam seg_pat_t SEG_PAT_7 = 7'b111_0000;
  localparam seg_pat_t SEG_PAT_8 = 7'b111_1111;
  localparam seg_pat_t SEG_PAT_9 = 7'b111_1011;
  localparam seg_pat_t SEG_PAT_A = 7'b111_0111;
  localparam seg_pat_t SEG_PAT_B = 7'b001_1111;
  localparam seg_pat_t SEG_PAT_C = 7'b100_1110;
  localparam seg_pat_t SEG_PAT_D = 7'b011_1101;
  localparam seg_pat_t SEG_PAT_E = 7'b100_1111;
  localparam seg_pat_t SEG_PAT_F = 7'b100_0111;

  // Code to active-high pattern; codes 10-15 are blank unless hex_mode
  function automatic seg_pat_t seg7_decode_fn(input logic [3:0] code, input logic hex_mode);
    seg_pat_t pat;
    pat = SEG_BLANK;
    case (code)
      4'd0:  pat = SEG_PAT_0;
      4'd1:  pat = SEG_PAT_1;
      4'd2:  pat = SEG_PAT_2;
      4'd3:  pat = SEG_PAT_3;
      4'd4:  pat = SEG_PAT_4;
      4'd5:  pat = SEG_PAT_5;
      4'd6:  pat = SEG_PAT_6;
      4'd7:  pat = SEG_PAT_7;
      4'd8:  pat = SEG_PAT_8;
      4'd9:  pat = SEG_PAT_9;
      4'd10: pat = hex_mode ? SEG_PAT_A : SEG_BLANK;
      4'd11: pat = hex_mode ? SEG_PAT_B : SEG_BLANK;
      4'd12: pat = hex_mode ? SEG_PAT_C : SEG_BLANK;
      4'd13: pat = hex_mode ? SEG_PAT_D : SEG_BLANK;
      4'd14: pat = hex_mode ? SEG_PAT_E : SEG_BLANK;
      4'd15: pat = hex_mode ? SEG_PAT_F : SEG_BLANK;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit code to active-high 7-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       code,
  input  logic             hex_mode,
  output logic [SEG_W-1:0] pattern_c
);

  // Table lookup through the shared decode function
  always_comb begin
    pattern_c = seg7_decode_fn(code, hex_mode);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with frame-latched inputs,
// hex decode, decimal points, blinking and leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned TICKS_PER_DIGIT = 100000,
  parameter int unsigned BLINK_FRAMES    = 32,
  parameter int unsigned HEX_MODE        = 0,
  parameter int unsigned SEG_ACTIVE_LOW  = 1,
  parameter int unsigned AN_ACTIVE_LOW   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned BW = 4 * NUM_DIGITS;
  localparam int unsigned PW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic HEX_EN  = (HEX_MODE != 0);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_INV}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  load_pend_q, load_pend_d;
  logic                  wrap_q, wrap_d;
  logic [BW-1:0]         bcd_sh_q, bcd_sh_d;
  logic [NUM_DIGITS-1:0] dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0] blink_sh_q, blink_sh_d;
  logic                  lz_sh_q, lz_sh_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fs_q, fs_d;

  logic                  tick_c, last_c, wrap_c, frame_last_c, load_c;
  logic [BW-1:0]         src_bcd_c;
  logic [NUM_DIGITS-1:0] src_dp_c, src_blink_c;
  logic                  src_lz_c;
  logic [3:0]            code_c;
  logic                  dp_bit_c, blink_bit_c, nz_seen_c;
  logic                  lz_blank_c, blink_blank_c;
  logic [NUM_DIGITS-1:0] an_sel_c;
  logic [SEG_W-1:0]      pat_c, pat_on_c;
  logic                  dp_on_c;

  // Prescaler, digit index, frame counter and shadow loading
  always_comb begin
    presc_d       = presc_q + PW'(1);
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    load_pend_d   = 1'b0;
    bcd_sh_d      = bcd_sh_q;
    dp_sh_d       = dp_sh_q;
    blink_sh_d    = blink_sh_q;
    lz_sh_d       = lz_sh_q;

    tick_c       = (presc_q == PW'(TICKS_PER_DIGIT - 1));
    last_c       = (idx_q == IW'(NUM_DIGITS - 1));
    wrap_c       = tick_c && last_c;
    frame_last_c = (frame_cnt_q == FW'(BLINK_FRAMES - 1));
    load_c       = wrap_c || load_pend_q;
    wrap_d       = wrap_c;

    if (tick_c) begin
      presc_d = '0;
      idx_d   = last_c ? '0 : idx_q + IW'(1);
    end

    if (wrap_c) begin
      frame_cnt_d = frame_last_c ? '0 : frame_cnt_q + FW'(1);
      if (frame_last_c) begin
        blink_phase_d = ~blink_phase_q;
      end
    end

    if (load_c) begin
      bcd_sh_d   = bcd;
      dp_sh_d    = dp_in;
      blink_sh_d = blink_en;
      lz_sh_d    = blank_lz;
    end
  end

  // The first edge after reset displays the live inputs it is latching,
  // so the opening dwell of digit 0 is not shown from cleared shadows
  always_comb begin
    src_bcd_c   = load_pend_q ? bcd      : bcd_sh_q;
    src_dp_c    = load_pend_q ? dp_in    : dp_sh_q;
    src_blink_c = load_pend_q ? blink_en : blink_sh_q;
    src_lz_c    = load_pend_q ? blank_lz : lz_sh_q;
  end

  // Select the current digit and detect leading zeros up to it
  always_comb begin
    code_c      = 4'd0;
    dp_bit_c    = 1'b0;
    blink_bit_c = 1'b0;
    nz_seen_c   = 1'b0;
    an_sel_c    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        code_c      = src_bcd_c[4*(NUM_DIGITS-1-i) +: 4];
        dp_bit_c    = src_dp_c[NUM_DIGITS-1-i];
        blink_bit_c = src_blink_c[NUM_DIGITS-1-i];
        an_sel_c[NUM_DIGITS-1-i] = 1'b1;
      end
      if ((IW'(i) <= idx_q) && (src_bcd_c[4*(NUM_DIGITS-1-i) +: 4] != 4'd0)) begin
        nz_seen_c = 1'b1;
      end
    end
    lz_blank_c    = src_lz_c && !last_c && !nz_seen_c;
    blink_blank_c = blink_bit_c && blink_phase_q;
  end

  seg7_decode u_decode (
    .code      (code_c),
    .hex_mode  (HEX_EN),
    .pattern_c (pat_c)
  );

  // Blanking, enable and pin polarity feeding the output registers
  always_comb begin
    pat_on_c = (blink_blank_c || lz_blank_c) ? SEG_BLANK : pat_c;
    dp_on_c  = blink_blank_c ? 1'b0 : dp_bit_c;
    seg_d    = pat_on_c ^ {SEG_W{SEG_INV}};
    dp_d     = dp_on_c ^ SEG_INV;
    an_d     = enable ? (an_sel_c ^ {NUM_DIGITS{AN_INV}}) : AN_OFF;
    fs_d     = wrap_q;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      load_pend_q   <= 1'b1;
      wrap_q        <= 1'b0;
      bcd_sh_q      <= '0;
      dp_sh_q       <= '0;
      blink_sh_q    <= '0;
      lz_sh_q       <= 1'b0;
      seg_q         <= SEG_OFF;
      dp_q          <= SEG_INV;
      an_q          <= AN_OFF;
      fs_q          <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      load_pend_q   <= load_pend_d;
      wrap_q        <= wrap_d;
      bcd_sh_q      <= bcd_sh_d;
      dp_sh_q       <= dp_sh_d;
      blink_sh_q    <= blink_sh_d;
      lz_sh_q       <= lz_sh_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      fs_q          <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule
